// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - HI/LO unit op encoding and shared constants
package hilo_pkg;

  typedef enum logic [2:0] {
    NOP  = 3'd0,
    WR   = 3'd1,
    MTHI = 3'd2,
    MTLO = 3'd3,
    MADD = 3'd4,
    MSUB = 3'd5
  } hilo_op_e;

  localparam int HILO_DATA_W_DEFAULT = 32;

  function automatic logic is_acc_op(input logic [2:0] op);
    return (op == MADD) || (op == MSUB);
  endfunction

endpackage

// File: rtl/hilo_acc_stage.sv
// rtl/hilo_acc_stage.sv - one-deep multiply-accumulate stage for HI/LO
module hilo_acc_stage
  import hilo_pkg::*;
#(
  parameter int DATA_W = HILO_DATA_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  sub_i,
  input  logic [2*DATA_W-1:0]   prod_i,
  input  logic [2*DATA_W-1:0]   hilo_i,
  output logic                  busy_o,
  output logic                  commit_o,
  output logic [2*DATA_W-1:0]   next_o
);

  logic                acc_valid;
  logic                acc_sub;
  logic [2*DATA_W-1:0] acc_prod;

  // start_i is only raised when idle, so acc_valid lasts exactly one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_valid <= 1'b0;
      acc_sub   <= 1'b0;
      acc_prod  <= '0;
    end else begin
      acc_valid <= start_i;
      if (start_i) begin
        acc_prod <= prod_i;
        acc_sub  <= sub_i;
      end
    end
  end

  assign busy_o   = acc_valid;
  assign commit_o = acc_valid;
  assign next_o   = acc_sub ? (hilo_i - acc_prod) : (hilo_i + acc_prod);

endmodule

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO architectural state with write, accumulate and read paths
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int                   DATA_W    = HILO_DATA_W_DEFAULT,
  parameter logic [2*DATA_W-1:0]  RESET_VAL = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  op_valid_i,
  input  logic [2:0]            op_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [2*DATA_W-1:0]   wdata_i,
  input  logic [1:0]            rd_sel_i,
  output logic [DATA_W-1:0]     rd_data_o,
  output logic [2*DATA_W-1:0]   hilo_o,
  output logic                  busy_o,
  output logic                  ready_o
);

  logic [2*DATA_W-1:0] hilo_q;
  logic [2*DATA_W-1:0] acc_next;
  logic                acc_busy;
  logic                acc_commit;
  logic                accept;
  logic                acc_start;

  assign accept    = op_valid_i & ~stall_i & ~flush_i & ~acc_busy & (op_i != NOP);
  assign acc_start = accept & is_acc_op(op_i);

  hilo_acc_stage #(.DATA_W(DATA_W)) u_acc (
    .clk      (clk),
    .rst      (rst),
    .start_i  (acc_start),
    .sub_i    (op_i == MSUB),
    .prod_i   (wdata_i),
    .hilo_i   (hilo_q),
    .busy_o   (acc_busy),
    .commit_o (acc_commit),
    .next_o   (acc_next)
  );

  // Commit and accept are mutually exclusive because busy gates accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hilo_q <= RESET_VAL;
    end else if (acc_commit) begin
      hilo_q <= acc_next;
    end else if (accept) begin
      case (op_i)
        WR:      hilo_q <= wdata_i;
        MTHI:    hilo_q[2*DATA_W-1:DATA_W] <= wdata_i[DATA_W-1:0];
        MTLO:    hilo_q[DATA_W-1:0]        <= wdata_i[DATA_W-1:0];
        default: hilo_q <= hilo_q;
      endcase
    end
  end

  assign rd_data_o = ({DATA_W{rd_sel_i[1]}} & hilo_q[2*DATA_W-1:DATA_W])
                   | ({DATA_W{rd_sel_i[0]}} & hilo_q[DATA_W-1:0]);
  assign hilo_o    = hilo_q;
  assign busy_o    = acc_busy;
  assign ready_o   = ~acc_busy;

  rd_sel_onehot: assert property (@(posedge clk) disable iff (rst) rd_sel_i != 2'b11)
    else $error("hilo_unit: rd_sel_i selects both HI and LO");

endmodule
